// File: rtl/miriscv_lsu_pkg.sv
// Shared LSU types and defaults for the data-memory arbiter slice.
package miriscv_lsu_pkg;

    localparam int XLEN = 32;
    localparam int DEFAULT_OUTSTANDING_DEPTH = 2;

    // Requester identity; also the payload stored per in-flight transaction.
    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_AUX  = 1'b1
    } owner_e;

    // The requester that is not the given one.
    function automatic owner_e other_owner(input owner_e owner);
        return (owner == OWNER_CORE) ? OWNER_AUX : OWNER_CORE;
    endfunction

endpackage

// File: rtl/miriscv_dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core port, aux port and memory port.
interface miriscv_dmem_arbiter_if;
    import miriscv_lsu_pkg::*;

    logic              c_req_i;
    logic              c_we_i;
    logic [XLEN/8-1:0] c_be_i;
    logic [XLEN-1:0]   c_addr_i;
    logic [XLEN-1:0]   c_wdata_i;
    logic              c_gnt_o;
    logic              c_rvalid_o;
    logic [XLEN-1:0]   c_rdata_o;
    logic              c_stall_req_o;

    logic              a_req_i;
    logic              a_we_i;
    logic [XLEN/8-1:0] a_be_i;
    logic [XLEN-1:0]   a_addr_i;
    logic [XLEN-1:0]   a_wdata_i;
    logic              a_gnt_o;
    logic              a_rvalid_o;
    logic [XLEN-1:0]   a_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    // Arbiter view.
    modport slave (
        input  c_req_i, c_we_i, c_be_i, c_addr_i, c_wdata_i,
        output c_gnt_o, c_rvalid_o, c_rdata_o, c_stall_req_o,
        input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    // Environment view (requesters and memory together).
    modport master (
        output c_req_i, c_we_i, c_be_i, c_addr_i, c_wdata_i,
        input  c_gnt_o, c_rvalid_o, c_rdata_o, c_stall_req_o,
        output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/miriscv_dmem_arb_fifo.sv
// Owner FIFO: remembers which requester issued each in-flight transaction so
// in-order memory responses can be routed back.
module miriscv_dmem_arb_fifo
    import miriscv_lsu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  owner_e                 i_data,
    output owner_e                 o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    owner_e          r_slots [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic            w_doPush;
    logic            w_doPop;

    // A push into a full FIFO is only legal alongside a pop of the head.
    assign w_doPop  = i_pop & (r_count != '0);
    assign w_doPush = i_push & ((r_count != DEPTH_CNT) | w_doPop);

    assign o_data  = r_slots[r_rdPtr];
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Pointer, occupancy and slot update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= OWNER_CORE;
            end
        end else begin
            if (w_doPush) begin
                r_slots[r_wrPtr] <= i_data;
                r_wrPtr          <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CW'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/miriscv_dmem_arbiter.sv
// Two-requester (core LSU / aux) data-memory arbiter with round-robin
// selection, a bounded number of in-flight transactions and in-order
// response routing.
module miriscv_dmem_arbiter
    import miriscv_lsu_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    miriscv_dmem_arbiter_if.slave  bus,
    output logic                   err_o
);

    localparam int CW = $clog2(OUTSTANDING_DEPTH) + 1;

    owner_e          r_lastWinner;
    owner_e          r_holdOwner;
    logic            r_holdValid;
    logic            r_err;

    owner_e          w_sel;
    owner_e          w_headOwner;
    logic            w_holdLive;
    logic            w_canIssue;
    logic            w_memReq;
    logic            w_accept;
    logic            w_respValid;
    logic            w_fifoFull;
    logic            w_fifoEmpty;
    logic [CW-1:0]   w_count;

    // A response only counts when something is outstanding; otherwise it is stray.
    assign w_respValid = bus.mem_rvalid_i & (w_count != '0);
    assign w_canIssue  = ~w_fifoFull | w_respValid;
    assign w_memReq    = (bus.c_req_i | bus.a_req_i) & w_canIssue;
    assign w_accept    = w_memReq & bus.mem_gnt_i;

    // A request offered but not accepted last cycle keeps ownership while still asserted.
    assign w_holdLive = r_holdValid &
                        (((r_holdOwner == OWNER_CORE) & bus.c_req_i) |
                         ((r_holdOwner == OWNER_AUX)  & bus.a_req_i));

    // Winner selection: frozen hold, else round-robin on a tie, else the sole requester.
    always_comb begin
        w_sel = OWNER_CORE;
        if (w_holdLive) begin
            w_sel = r_holdOwner;
        end else if (bus.c_req_i && bus.a_req_i) begin
            w_sel = other_owner(r_lastWinner);
        end else if (bus.a_req_i) begin
            w_sel = OWNER_AUX;
        end
    end

    assign bus.mem_req_o   = w_memReq;
    assign bus.mem_we_o    = (w_sel == OWNER_AUX) ? bus.a_we_i    : bus.c_we_i;
    assign bus.mem_be_o    = (w_sel == OWNER_AUX) ? bus.a_be_i    : bus.c_be_i;
    assign bus.mem_addr_o  = (w_sel == OWNER_AUX) ? bus.a_addr_i  : bus.c_addr_i;
    assign bus.mem_wdata_o = (w_sel == OWNER_AUX) ? bus.a_wdata_i : bus.c_wdata_i;

    assign bus.c_gnt_o       = w_accept & (w_sel == OWNER_CORE);
    assign bus.a_gnt_o       = w_accept & (w_sel == OWNER_AUX);
    assign bus.c_stall_req_o = bus.c_req_i & ~bus.c_gnt_o;

    assign bus.c_rvalid_o = w_respValid & (w_headOwner == OWNER_CORE);
    assign bus.a_rvalid_o = w_respValid & (w_headOwner == OWNER_AUX);
    assign bus.c_rdata_o  = bus.mem_rdata_i;
    assign bus.a_rdata_o  = bus.mem_rdata_i;

    assign err_o = r_err;

    miriscv_dmem_arb_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .i_push  (w_accept),
        .i_pop   (w_respValid),
        .i_data  (w_sel),
        .o_data  (w_headOwner),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_count)
    );

    // Round-robin pointer, stalled-request hold and sticky stray-response flag.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_lastWinner <= OWNER_AUX;
            r_holdOwner  <= OWNER_CORE;
            r_holdValid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lastWinner <= w_sel;
            end
            r_holdValid <= w_memReq & ~bus.mem_gnt_i;
            r_holdOwner <= w_sel;
            if (bus.mem_rvalid_i && w_fifoEmpty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
